// File: rtl/mask_stream_tx_if.sv
// Pixel stream handshake between an upstream source and mask_stream_tx.
// The master drives valid/sof/data; the slave returns ready.
interface mask_stream_tx_if;
  logic       valid;
  logic       sof;
  logic [7:0] data;
  logic       ready;

  modport master (output valid, output sof, output data, input ready);
  modport slave  (input valid, input sof, input data, output ready);
endinterface

// File: rtl/mask_stream_tx.sv
// Raster transmitter: pulls SOF-marked pixels from a stream and emits de/hsync/vsync
// timing aligned to the source frame, with sticky underrun/resync status.
module mask_stream_tx #(
  parameter int H_SIZE       = 83,
  parameter int H_ACTIVE     = 64,
  parameter int H_SYNC_START = 70,
  parameter int H_SYNC_LEN   = 6,
  parameter int V_SIZE       = 70,
  parameter int V_ACTIVE     = 60,
  parameter int V_SYNC_START = 63,
  parameter int V_SYNC_LEN   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic             enable,
  mask_stream_tx_if.slave  pix,
  output logic             de_out,
  output logic             hsync_out,
  output logic             vsync_out,
  output logic [7:0]       pixel_out,
  output logic             frame_start,
  output logic             underrun,
  output logic             resync_err,
  input  logic             clear_status
);

  localparam logic [11:0] H_LAST = 12'(H_SIZE - 1);
  localparam logic [11:0] V_LAST = 12'(V_SIZE - 1);

  typedef enum logic [1:0] {IDLE, SYNC_WAIT, RUN} state_t;

  state_t      state_reg, state_next;
  logic [11:0] h_cnt_reg, v_cnt_reg;
  logic        err_pending_reg;

  logic        active, hs, vs, at_origin, frame_end;
  logic        pop, sof_err, starve;
  logic        de_next, hs_next, vs_next, fs_next;
  logic [7:0]  px_next;

  assign active    = (h_cnt_reg < 12'(H_ACTIVE)) && (v_cnt_reg < 12'(V_ACTIVE));
  assign hs        = (h_cnt_reg >= 12'(H_SYNC_START)) &&
                     (h_cnt_reg <  12'(H_SYNC_START + H_SYNC_LEN));
  assign vs        = (v_cnt_reg >= 12'(V_SYNC_START)) &&
                     (v_cnt_reg <  12'(V_SYNC_START + V_SYNC_LEN));
  assign at_origin = (h_cnt_reg == 12'd0) && (v_cnt_reg == 12'd0);
  assign frame_end = (h_cnt_reg == H_LAST) && (v_cnt_reg == V_LAST);

  assign pop     = pix.ready && pix.valid;
  // A frame must open with SOF at (0,0) and carry no SOF anywhere else.
  assign sof_err = ce && (state_reg == RUN) && active && pix.valid &&
                   (at_origin ? !pix.sof : pix.sof);
  assign starve  = ce && (state_reg == RUN) && active && !pix.valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else if (ce) begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (ce) begin
      unique case (state_reg)
        IDLE: begin
          if (enable) state_next = SYNC_WAIT;
        end
        SYNC_WAIT: begin
          if (frame_end) begin
            if (!enable)                      state_next = IDLE;
            else if (pix.valid && pix.sof)    state_next = RUN;
          end
        end
        RUN: begin
          if (frame_end) begin
            if (!enable)                           state_next = IDLE;
            else if (err_pending_reg || sof_err)   state_next = SYNC_WAIT;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    pix.ready = 1'b0;
    de_next   = 1'b0;
    hs_next   = 1'b0;
    vs_next   = 1'b0;
    fs_next   = 1'b0;
    px_next   = 8'd0;
    unique case (state_reg)
      IDLE: begin
      end
      SYNC_WAIT: begin
        // Drain stale words; the SOF word stays at the head for RUN.
        pix.ready = ce && pix.valid && !pix.sof;
        hs_next   = hs;
        vs_next   = vs;
      end
      RUN: begin
        pix.ready = ce && active;
        de_next   = active;
        hs_next   = hs;
        vs_next   = vs;
        fs_next   = at_origin;
        if (pop && !(at_origin && !pix.sof)) px_next = pix.data;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_reg       <= 12'd0;
      v_cnt_reg       <= 12'd0;
      err_pending_reg <= 1'b0;
      de_out          <= 1'b0;
      hsync_out       <= 1'b0;
      vsync_out       <= 1'b0;
      frame_start     <= 1'b0;
      pixel_out       <= 8'd0;
      underrun        <= 1'b0;
      resync_err      <= 1'b0;
    end else if (ce) begin
      if (state_reg == IDLE) begin
        h_cnt_reg <= 12'd0;
        v_cnt_reg <= 12'd0;
      end else if (h_cnt_reg == H_LAST) begin
        h_cnt_reg <= 12'd0;
        v_cnt_reg <= (v_cnt_reg == V_LAST) ? 12'd0 : v_cnt_reg + 12'd1;
      end else begin
        h_cnt_reg <= h_cnt_reg + 12'd1;
      end

      if (state_reg == RUN && !frame_end) err_pending_reg <= err_pending_reg | sof_err;
      else                                err_pending_reg <= 1'b0;

      de_out      <= de_next;
      hsync_out   <= hs_next;
      vsync_out   <= vs_next;
      frame_start <= fs_next;
      pixel_out   <= px_next;

      // Setting an error takes priority over a simultaneous clear.
      if (starve)            underrun <= 1'b1;
      else if (clear_status) underrun <= 1'b0;

      if (sof_err)           resync_err <= 1'b1;
      else if (clear_status) resync_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mask_stream_tx.sv
// Directed bench for mask_stream_tx on a 10x5 raster (6x3 active, 18 words per frame).
// Expected raster values are computed from frame position and the source word index.
module tb_mask_stream_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ce = 1'b1;
  logic       enable = 1'b0;
  logic       clear = 1'b0;
  logic       de, hs, vs, fs, ur, re;
  logic [7:0] px;

  mask_stream_tx_if pix_if ();

  mask_stream_tx #(
    .H_SIZE(10), .H_ACTIVE(6), .H_SYNC_START(7), .H_SYNC_LEN(2),
    .V_SIZE(5),  .V_ACTIVE(3), .V_SYNC_START(3), .V_SYNC_LEN(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .enable(enable), .pix(pix_if),
    .de_out(de), .hsync_out(hs), .vsync_out(vs), .pixel_out(px),
    .frame_start(fs), .underrun(ur), .resync_err(re), .clear_status(clear)
  );

  always #5 clk = ~clk;

  int  n_vec = 0;
  int  n_err = 0;
  int  src_idx, src_off, inj_idx;
  bit  ce_mode;
  bit  ur_e, re_e;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] obs();
    return {2'b00, de, hs, vs, fs, ur, re, px};
  endfunction

  // Source: data is the word index; SOF every 18 words from src_off, plus an optional injected SOF.
  task automatic drive_src();
    pix_if.data = 8'(src_idx);
    pix_if.sof  = (((src_idx - src_off) % 18) == 0) || (src_idx == inj_idx);
  endtask

  // A word offered while ready is high is consumed; a stalled source drops that slot's word.
  task automatic tick();
    logic rdy;
    @(negedge clk);
    rdy = pix_if.ready;
    if (!ce) check("ready_ce0", 16'(rdy), 16'd0);
    @(posedge clk);
    #1;
    if (rdy) begin
      src_idx++;
      drive_src();
    end
  endtask

  task automatic cmp(input int k, input int base, input bit run, input int drop_k);
    int h, v;
    bit act, e_de, e_hs, e_vs, e_fs;
    logic [7:0] e_px;
    h    = k % 10;
    v    = k / 10;
    act  = (h < 6) && (v < 3);
    e_de = run && act;
    e_hs = (h == 7) || (h == 8);
    e_vs = (v == 3);
    e_fs = run && (k == 0);
    e_px = e_de ? 8'(base + v * 6 + h) : 8'd0;
    if (drop_k >= 0 && (k == drop_k || k == drop_k + 1)) e_px = 8'd0;
    check($sformatf("pos%0d_b%0d", k, base), obs(),
          {2'b00, e_de, e_hs, e_vs, e_fs, ur_e, re_e, e_px});
  endtask

  task automatic wait_fs();
    for (int n = 0; n < 300; n++) begin
      tick();
      if (fs) break;
      if (ce_mode) begin
        ce = 1'b0;
        tick();
        ce = 1'b1;
      end
    end
    check("frame_start_seen", 16'(fs), 16'd1);
  endtask

  // One 50-clock frame starting at the output of position (0,0).
  task automatic check_frame(input int base, input bit run, input int drop_k,
                             input int inj_p, input int clr_k);
    int inj_k;
    inj_k = -1;
    if (inj_p >= 0) begin
      inj_idx = base + inj_p;
      inj_k   = (inj_p / 6) * 10 + (inj_p % 6);
    end
    for (int k = 0; k < 50; k++) begin
      if (drop_k >= 0 && k == drop_k) ur_e = 1'b1;
      if (inj_k >= 0 && k == inj_k) re_e = 1'b1;
      if (clr_k >= 0 && k == clr_k + 1) begin
        ur_e = 1'b0;
        re_e = 1'b0;
      end
      cmp(k, base, run, drop_k);
      if (ce_mode) begin
        ce = 1'b0;
        tick();
        cmp(k, base, run, drop_k);
        ce = 1'b1;
      end
      if (drop_k >= 0 && k == drop_k - 1) pix_if.valid = 1'b0;
      if (drop_k >= 0 && k == drop_k + 1) pix_if.valid = 1'b1;
      if (clr_k >= 0 && k == clr_k)       clear = 1'b1;
      if (clr_k >= 0 && k == clr_k + 1)   clear = 1'b0;
      tick();
    end
    $display("frame base=%0d run=%0d drop=%0d inj=%0d clr=%0d vectors=%0d",
             base, run, drop_k, inj_p, clr_k, n_vec);
  endtask

  task automatic do_reset(input int off);
    rst_n        = 1'b0;
    enable       = 1'b0;
    clear        = 1'b0;
    ce           = 1'b1;
    ce_mode      = 1'b0;
    src_idx      = 0;
    src_off      = off;
    inj_idx      = -1;
    pix_if.valid = 1'b1;
    drive_src();
    ur_e         = 1'b0;
    re_e         = 1'b0;
    repeat (3) tick();
    check("reset_outputs", obs(), 16'd0);
    check("reset_ready", 16'(pix_if.ready), 16'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    // Aligned source, continuous frames.
    do_reset(0);
    enable = 1'b1;
    wait_fs();
    check_frame(0, 1'b1, -1, -1, -1);
    check_frame(18, 1'b1, -1, -1, -1);

    // Four stale words ahead of the first SOF, then underrun, clear, and SOF misalignment.
    do_reset(4);
    enable = 1'b1;
    wait_fs();
    check_frame(4, 1'b1, -1, -1, -1);
    check("stale_resync", 16'(re), 16'd0);
    check_frame(22, 1'b1, 13, -1, -1);
    check("underrun_set", 16'(ur), 16'd1);
    check_frame(40, 1'b1, -1, -1, 20);
    check("underrun_cleared", 16'(ur), 16'd0);
    check_frame(58, 1'b1, -1, 10, -1);
    check("resync_set", 16'(re), 16'd1);
    check_frame(76, 1'b0, -1, -1, -1);
    check_frame(76, 1'b1, -1, -1, 5);
    check("resync_cleared", 16'(re), 16'd0);

    // Clock enable toggling every cycle.
    do_reset(0);
    ce_mode = 1'b1;
    enable  = 1'b1;
    wait_fs();
    check_frame(0, 1'b1, -1, -1, -1);
    check_frame(18, 1'b1, -1, -1, -1);

    // Asynchronous reset mid-line; the source keeps its position and must be re-aligned.
    ce_mode = 1'b0;
    repeat (3) tick();
    cmp(3, 36, 1'b1, -1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", obs(), 16'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    wait_fs();
    check_frame(54, 1'b1, -1, -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mask_stream_tx.md
Name: mask_stream_tx

Overview:
Video stream transmitter for the neuro_skin pixel pipeline. It pulls 8-bit pixels from an upstream valid/ready source that carries a start-of-frame marker. It emits a raster with de/hsync/vsync and a timing grid that the downstream filter chain, including the 5x5 mask filters, consumes directly. It owns frame timing, frame alignment to the source, and underrun/misalignment reporting.

Parameters:
H_SIZE, 83, total clocks per line (active + blanking)
H_ACTIVE, 64, active pixels per line (h_cnt 0..H_ACTIVE-1)
H_SYNC_START, 70, h_cnt at which hsync rises
H_SYNC_LEN, 6, hsync width in clocks
V_SIZE, 70, total lines per frame
V_ACTIVE, 60, active lines (v_cnt 0..V_ACTIVE-1)
V_SYNC_START, 63, line at which vsync rises
V_SYNC_LEN, 2, vsync width in lines

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
ce  in  1  clock enable; when 0 all state and outputs hold
enable  in  1  transmit request
pix_valid  in  1  upstream word valid
pix_sof  in  1  upstream word is first pixel of a frame
pix_data  in  8  upstream pixel
pix_ready  out  1  word consumed this cycle (combinational)
de_out  out  1  data enable
hsync_out  out  1  horizontal sync, active high
vsync_out  out  1  vertical sync, active high
pixel_out  out  8  pixel
frame_start  out  1  1-cycle pulse with the first active pixel of each RUN frame
underrun  out  1  sticky: active pixel had no valid word
resync_err  out  1  sticky: SOF misalignment detected
clear_status  in  1  clears underrun and resync_err (sync, qualified by ce)

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, h_cnt=v_cnt=0, all outputs 0, sticky flags 0.
- Counters: 12-bit h_cnt and v_cnt. They advance on clk when ce=1 and state≠IDLE. h_cnt wraps at H_SIZE-1→0 and then increments v_cnt. v_cnt wraps at V_SIZE-1→0.
- Decodes from the counters:
  - active = h_cnt<H_ACTIVE && v_cnt<V_ACTIVE
  - hs = H_SYNC_START ≤ h_cnt < H_SYNC_START+H_SYNC_LEN
  - vs = V_SYNC_START ≤ v_cnt < V_SYNC_START+V_SYNC_LEN, held for whole lines
- Outputs are registered, 1 clock after the counter state:
  - de_out = active && state==RUN
  - hsync_out = hs, vsync_out = vs in SYNC_WAIT and RUN; both 0 in IDLE
  - pixel_out = popped pix_data if de_out would be 1 and the pop succeeded, else 0
- States:
  - IDLE: counters held at 0, outputs 0, pix_ready=0. enable=1 → SYNC_WAIT on the next ce cycle.
  - SYNC_WAIT: timing runs with de_out=0.
    - pix_ready = ce && pix_valid && !pix_sof, which drains words until an SOF word is at the head. The SOF word is not popped.
    - Transition to RUN when the head is SOF (pix_valid && pix_sof) and the counters are at h_cnt=H_SIZE-1, v_cnt=V_SIZE-1, so the next cycle is pixel (0,0).
    - If enable=0 at that point → IDLE.
  - RUN:
    - pix_ready = ce && active. A pop happens only if pix_valid=1.
    - At (0,0): the popped word must carry sof=1. If sof=0 → set resync_err, output that pixel as 0 with de_out=1, and go to SYNC_WAIT at the frame end.
    - At any other active position: a popped word with sof=1 → set resync_err, the word is consumed and output, and go to SYNC_WAIT at the frame end.
    - Active position with pix_valid=0 → set underrun, pixel_out=0, de_out=1; timing is never stretched.
    - At the frame end (h=H_SIZE-1, v=V_SIZE-1): enable=0 → IDLE; pending error → SYNC_WAIT; otherwise stay in RUN.
- frame_start is registered alongside de_out at position (0,0) in RUN.
- A simultaneous error set and clear_status → set wins.
- Deasserting enable mid-frame has no effect until the frame end.
- Reset mid-frame aborts immediately with no partial-line completion.
- ce=0: pix_ready=0 and no counter, state or flag update.

Test Plan:
1. Params H_SIZE=10, H_ACTIVE=6, H_SYNC_START=7, H_SYNC_LEN=2, V_SIZE=5, V_ACTIVE=3, V_SYNC_START=3, V_SYNC_LEN=1; source always valid, SOF on every 18th word, data=index → per line 6 de clocks with pixel 0..5, hsync high at h=7,8; vsync high for all of line 3; frame_start once per 50 clocks; flags stay 0.
2. Source holds 4 non-SOF words before the first SOF → those 4 words are drained in SYNC_WAIT; the first de pixel equals the SOF word's data; resync_err=0.
3. pix_valid dropped for 2 clocks mid-line in RUN → pixel_out=0 for exactly those 2 de clocks; underrun=1 and stays 1 until clear_status; sync timing unchanged.
4. SOF injected at pixel 10 of a frame → resync_err=1; the frame completes; next state is SYNC_WAIT; de_out=0 until the next aligned SOF at (0,0).
5. ce toggled 1/0 every cycle → the output waveform is identical to test 1 sampled on ce cycles; pix_ready=0 whenever ce=0.
6. rst_n asserted low mid-line → all outputs 0 immediately (asynchronously); after release with enable=1, SYNC_WAIT is entered, then RUN at the next aligned SOF.
